// File: rtl/arilla_bus_arbiter.sv
// Multi-controller arbiter for the arilla bus: one transaction in flight, round-robin or fixed priority,
// with decode-miss and timeout fault completion and a timeout freeze while the bus is intercepted.
module arilla_bus_arbiter #(
  parameter int NumCtl           = 2,
  parameter int DataWidth        = 32,
  parameter int ByteAddressWidth = 32,
  parameter int ByteSize         = 8,
  parameter int ArbMode          = 0,
  parameter int TimeoutCycles    = 256,
  localparam int BytesPerWord     = DataWidth / ByteSize,
  localparam int WordAddressWidth = ByteAddressWidth - $clog2(BytesPerWord)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumCtl*DataWidth-1:0]        c_data_ctp,
  input  logic [NumCtl*WordAddressWidth-1:0] c_address,
  input  logic [NumCtl*BytesPerWord-1:0]     c_byte_enable,
  input  logic [NumCtl-1:0]                  c_read,
  input  logic [NumCtl-1:0]                  c_write,
  output logic [DataWidth-1:0]               c_data_ptc,
  output logic [NumCtl-1:0]                  c_available,
  output logic [NumCtl-1:0]                  c_intercept,
  output logic [NumCtl-1:0]                  c_hit,
  output logic [NumCtl-1:0]                  c_fault,
  output logic [DataWidth-1:0]               p_data_ctp,
  output logic [WordAddressWidth-1:0]        p_address,
  output logic [BytesPerWord-1:0]            p_byte_enable,
  output logic                               p_read,
  output logic                               p_write,
  input  logic [DataWidth-1:0]               p_data_ptc,
  input  logic                               p_available,
  input  logic                               p_intercept,
  input  logic                               p_hit,
  output logic [NumCtl-1:0]                  grant
);

  localparam int WaitWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int PtrWidth  = (NumCtl > 1) ? $clog2(NumCtl) : 1;
  localparam logic [WaitWidth-1:0] WaitLast = WaitWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [PtrWidth-1:0]  PtrLast  = PtrWidth'(NumCtl - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]           state;
  logic [PtrWidth-1:0]  grant_idx;
  logic [PtrWidth-1:0]  rr_ptr;
  logic [PtrWidth-1:0]  win_idx;
  logic [WaitWidth-1:0] wait_cnt;
  logic [NumCtl-1:0]    req;
  logic                 busy, rd_g, wr_g, req_g, abort;
  logic                 cpl_ok, cpl_miss, cpl_tmo, fault, done;

  assign req  = c_read | c_write;
  assign busy = (state == ST_BUSY);

  always_comb begin
    logic                found;
    logic [PtrWidth:0]   sum;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    if (ArbMode == 1) begin
      for (int i = NumCtl - 1; i >= 0; i--) begin
        if (req[i]) win_idx = PtrWidth'(i);
      end
    end else begin
      // scan from rr_ptr upward, wrapping past the last controller
      for (int k = 0; k < NumCtl; k++) begin
        sum = {1'b0, rr_ptr} + (PtrWidth + 1)'(k);
        if (sum >= (PtrWidth + 1)'(NumCtl)) sum = sum - (PtrWidth + 1)'(NumCtl);
        if (!found && req[sum[PtrWidth-1:0]]) begin
          win_idx = sum[PtrWidth-1:0];
          found   = 1'b1;
        end
      end
    end
  end

  assign rd_g     = c_read[grant_idx];
  assign wr_g     = c_write[grant_idx];
  assign req_g    = busy & (rd_g | wr_g);
  assign abort    = busy & ~(rd_g | wr_g);
  assign cpl_ok   = req_g & p_available;
  assign cpl_miss = req_g & ~p_available & ~p_hit;
  // a frozen (intercepted) bus must not time out
  assign cpl_tmo  = (TimeoutCycles > 0) && req_g && !p_available && p_hit && !p_intercept &&
                    (wait_cnt == WaitLast);
  assign fault    = cpl_miss | cpl_tmo;
  assign done     = cpl_ok | fault | abort;

  assign p_read        = req_g & rd_g & ~fault;
  assign p_write       = req_g & wr_g & ~fault;
  assign p_data_ctp    = busy ? c_data_ctp[int'(grant_idx)*DataWidth +: DataWidth] : '0;
  assign p_address     = busy ? c_address[int'(grant_idx)*WordAddressWidth +: WordAddressWidth] : '0;
  assign p_byte_enable = busy ? c_byte_enable[int'(grant_idx)*BytesPerWord +: BytesPerWord] : '0;

  assign c_data_ptc  = cpl_ok ? p_data_ptc : '0;
  assign c_available = grant & {NumCtl{cpl_ok | fault}};
  assign c_fault     = grant & {NumCtl{fault}};
  assign c_hit       = grant & {NumCtl{p_hit}};
  assign c_intercept = grant & {NumCtl{p_intercept}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state     <= ST_BUSY;
            grant     <= NumCtl'(1) << win_idx;
            grant_idx <= win_idx;
            wait_cnt  <= '0;
          end
        end
        ST_BUSY: begin
          if (done) begin
            state    <= ST_IDLE;
            grant    <= '0;
            wait_cnt <= '0;
            if ((cpl_ok || fault) && ArbMode == 0) begin
              rr_ptr <= (grant_idx == PtrLast) ? '0 : grant_idx + 1'b1;
            end
          end else if (!p_intercept && TimeoutCycles > 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Bench for arilla_bus_arbiter: directed vector table, hand-written abort/reset/fairness sequences,
// and a randomized run against a transaction-level reference model.
module tb_arilla_bus_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int BW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*DW-1:0] c_data_ctp;
  logic [N*AW-1:0] c_address;
  logic [N*BW-1:0] c_byte_enable;
  logic [N-1:0]    c_read, c_write;
  logic [DW-1:0]   c_data_ptc;
  logic [N-1:0]    c_available, c_intercept, c_hit, c_fault, grant;
  logic [DW-1:0]   p_data_ctp;
  logic [AW-1:0]   p_address;
  logic [BW-1:0]   p_byte_enable;
  logic            p_read, p_write;
  logic [DW-1:0]   p_data_ptc;
  logic            p_available, p_intercept, p_hit;

  logic [DW-1:0]   f_data_ptc, f_data_ctp;
  logic [N-1:0]    f_available, f_intercept, f_hit, f_fault, f_grant;
  logic [AW-1:0]   f_address;
  logic [BW-1:0]   f_byte_enable;
  logic            f_read, f_write;

  arilla_bus_arbiter #(.NumCtl(N), .DataWidth(DW), .ByteAddressWidth(32), .ByteSize(8),
                       .ArbMode(0), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst(rst), .c_data_ctp(c_data_ctp), .c_address(c_address),
    .c_byte_enable(c_byte_enable), .c_read(c_read), .c_write(c_write),
    .c_data_ptc(c_data_ptc), .c_available(c_available), .c_intercept(c_intercept),
    .c_hit(c_hit), .c_fault(c_fault), .p_data_ctp(p_data_ctp), .p_address(p_address),
    .p_byte_enable(p_byte_enable), .p_read(p_read), .p_write(p_write),
    .p_data_ptc(p_data_ptc), .p_available(p_available), .p_intercept(p_intercept),
    .p_hit(p_hit), .grant(grant));

  // fixed-priority instance with an always-ready peripheral
  arilla_bus_arbiter #(.NumCtl(N), .DataWidth(DW), .ByteAddressWidth(32), .ByteSize(8),
                       .ArbMode(1), .TimeoutCycles(TO)) dut_fixed (
    .clk(clk), .rst(rst), .c_data_ctp(c_data_ctp), .c_address(c_address),
    .c_byte_enable(c_byte_enable), .c_read(c_read), .c_write(c_write),
    .c_data_ptc(f_data_ptc), .c_available(f_available), .c_intercept(f_intercept),
    .c_hit(f_hit), .c_fault(f_fault), .p_data_ctp(f_data_ctp), .p_address(f_address),
    .p_byte_enable(f_byte_enable), .p_read(f_read), .p_write(f_write),
    .p_data_ptc('0), .p_available(1'b1), .p_intercept(1'b0),
    .p_hit(1'b1), .grant(f_grant));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] rd, wr;
    logic       av, hit, intc;
    logic [2:0] grant;
    logic       pr, pw;
    logic [2:0] cav, cf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] rd, input logic [2:0] wr, input logic av, input logic hit,
                     input logic intc, input logic [2:0] g, input logic pr, input logic pw,
                     input logic [2:0] cav, input logic [2:0] cf);
    vec_t v;
    v = '{rd, wr, av, hit, intc, g, pr, pw, cav, cf};
    tbl.push_back(v);
  endtask

  // random-phase controller and model state
  bit          act[N];
  bit          isw[N];
  logic [AW-1:0] raddr[N];
  logic [DW-1:0] rdat[N];
  bit          m_busy;
  int          m_owner, m_ptr, m_wait;

  initial begin
    logic [2:0]  gq[$];
    logic [2:0]  exp_seq[6];
    int          fcount;
    logic [2:0]  e_grant, e_av, e_f, e_hit;
    logic        e_pr, e_pw, ok, miss, tmo;
    logic [DW-1:0] e_data;

    rst = 1'b1;
    c_read = '0; c_write = '0;
    p_available = 1'b0; p_hit = 1'b0; p_intercept = 1'b0; p_data_ptc = '0;
    for (int i = 0; i < N; i++) begin
      c_address[i*AW +: AW]   = AW'(32'h10 + 32'h100 * i);
      c_data_ctp[i*DW +: DW]  = 32'hA5A50000 + i;
      c_byte_enable[i*BW +: BW] = 4'hF;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset grant", grant, 0);
    check("reset c_available", c_available, 0);
    check("reset p_strobes", {p_read, p_write}, 0);
    check("reset c_data_ptc", c_data_ptc, 0);
    check("reset p_address", p_address, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single read, decode miss, timeout, timeout with intercept freeze
    add(3'b001, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(3'b001, 3'b000, 0, 1, 0, 3'b001, 1, 0, 3'b000, 3'b000);
    add(3'b001, 3'b000, 0, 1, 0, 3'b001, 1, 0, 3'b000, 3'b000);
    add(3'b001, 3'b000, 1, 1, 0, 3'b001, 1, 0, 3'b001, 3'b000);
    add(3'b000, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(3'b000, 3'b010, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(3'b000, 3'b010, 0, 0, 0, 3'b010, 0, 0, 3'b010, 3'b010);
    add(3'b000, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(3'b100, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) add(3'b100, 3'b000, 0, 1, 0, 3'b100, 1, 0, 3'b000, 3'b000);
    add(3'b100, 3'b000, 0, 1, 0, 3'b100, 0, 0, 3'b100, 3'b100);
    add(3'b000, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(3'b001, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);
    add(3'b001, 3'b000, 0, 1, 0, 3'b001, 1, 0, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) add(3'b001, 3'b000, 0, 1, 1, 3'b001, 1, 0, 3'b000, 3'b000);
    for (int i = 0; i < 2; i++) add(3'b001, 3'b000, 0, 1, 0, 3'b001, 1, 0, 3'b000, 3'b000);
    add(3'b001, 3'b000, 0, 1, 0, 3'b001, 0, 0, 3'b001, 3'b001);
    add(3'b000, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000);

    p_data_ptc = 32'hDEADBEEF;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      c_read = tbl[i].rd; c_write = tbl[i].wr;
      p_available = tbl[i].av; p_hit = tbl[i].hit; p_intercept = tbl[i].intc;
      @(negedge clk);
      check($sformatf("row%0d grant", i), grant, tbl[i].grant);
      check($sformatf("row%0d p_read/p_write", i), {p_read, p_write}, {tbl[i].pr, tbl[i].pw});
      check($sformatf("row%0d c_available", i), c_available, tbl[i].cav);
      check($sformatf("row%0d c_fault", i), c_fault, tbl[i].cf);
      if (tbl[i].cav != 0)
        check($sformatf("row%0d c_data_ptc", i), c_data_ptc, (tbl[i].cf != 0) ? 32'h0 : 32'hDEADBEEF);
      if (tbl[i].grant == 3'b001)
        check($sformatf("row%0d p_address", i), p_address, 30'h10);
    end

    // abort: ctl1 drops its read while waiting
    @(posedge clk); #1 c_read = 3'b010; p_available = 1'b0; p_hit = 1'b1; p_intercept = 1'b0;
    @(negedge clk); check("abort idle grant", grant, 0);
    @(posedge clk); #1;
    @(negedge clk); check("abort busy grant", grant, 3'b010); check("abort busy p_read", p_read, 1);
    @(posedge clk); #1 c_read = 3'b000;
    @(negedge clk); check("abort p_read drop", p_read, 0); check("abort no c_available", c_available, 0);
    @(posedge clk); #1;
    @(negedge clk); check("abort back to idle", grant, 0);

    // reset while busy, then round-robin fairness from a fresh pointer
    @(posedge clk); #1 c_read = 3'b100;
    @(posedge clk); #1;
    @(negedge clk); check("pre-reset grant", grant, 3'b100);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async reset grant", grant, 0);
    check("async reset p_read", p_read, 0);
    check("async reset p_address", p_address, 0);
    check("async reset c_hit", c_hit, 0);
    c_read = 3'b111; p_available = 1'b1; p_hit = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant != 0) gq.push_back(grant);
      if (f_grant != 0) begin
        check("fixed-priority grant", f_grant, 3'b001);
        fcount++;
      end
    end
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    check("rr grant count", gq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) check($sformatf("rr grant %0d", i), gq[i], exp_seq[i]);
    end
    check("fixed grant count", fcount, 6);

    // randomized run against the reference model
    @(posedge clk); #1;
    c_read = '0; c_write = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < N; i++) act[i] = 0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(2) == 0) begin
          act[i] = 1; isw[i] = 1'($urandom_range(1));
          raddr[i] = AW'($urandom); rdat[i] = $urandom;
        end
        c_read[i]  = act[i] && !isw[i];
        c_write[i] = act[i] && isw[i];
        c_address[i*AW +: AW]  = raddr[i];
        c_data_ctp[i*DW +: DW] = rdat[i];
      end
      p_available = ($urandom_range(3) == 0);
      p_hit       = ($urandom_range(7) != 0);
      p_intercept = ($urandom_range(3) == 0);
      p_data_ptc  = $urandom;
      @(negedge clk);
      e_grant = 0; e_av = 0; e_f = 0; e_hit = 0; e_pr = 0; e_pw = 0; e_data = 0;
      ok = 0; miss = 0; tmo = 0;
      if (m_busy) begin
        e_grant = 3'(1 << m_owner);
        e_hit   = p_hit ? e_grant : 3'b000;
        ok   = p_available;
        miss = !ok && !p_hit;
        tmo  = !ok && p_hit && !p_intercept && (m_wait == TO - 1);
        if (ok || miss || tmo) e_av = e_grant;
        if (miss || tmo) e_f = e_grant;
        if (ok) e_data = p_data_ptc;
        if (!(miss || tmo)) begin e_pr = !isw[m_owner]; e_pw = isw[m_owner]; end
      end
      check("rand grant", grant, e_grant);
      check("rand p_read/p_write", {p_read, p_write}, {e_pr, e_pw});
      check("rand c_available", c_available, e_av);
      check("rand c_fault", c_fault, e_f);
      check("rand c_hit", c_hit, e_hit);
      check("rand c_data_ptc", c_data_ptc, e_data);
      if (m_busy) check("rand p_address", p_address, raddr[m_owner]);
      if (m_busy) begin
        if (ok || miss || tmo) begin
          act[m_owner] = 0;
          m_busy = 0;
          m_ptr  = (m_owner + 1) % N;
          m_wait = 0;
        end else if (!p_intercept) begin
          m_wait++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!m_busy && act[(m_ptr + k) % N]) begin
            m_busy  = 1;
            m_owner = (m_ptr + k) % N;
            m_wait  = 0;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
